mspc_v_decode_fetch: RTL

MSPC_V_DECODE_FETCH -- requirements
Module: mspc_v_decode_fetch

---
 rtl/mspc_v_pkg.sv | 48 ++++
 rtl/mspc_v_regfile.sv | 29 ++
 rtl/mspc_v_decode_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mspc_v_pkg.sv
// Shared definitions for the mspc_v datapath: machine widths, instruction
// field positions and the ALU operation encoding used by decode and ALU.
package mspc_v_pkg;

    localparam int XLEN    = 64;
    localparam int NREG    = 32;
    localparam int REG_AW  = 5;
    localparam int INSTR_W = 32;

    // Instruction field positions (bit indices into instr)
    localparam int SEL_HI     = 31;
    localparam int SEL_LO     = 28;
    localparam int RD_HI      = 27;
    localparam int RD_LO      = 23;
    localparam int RS1_HI     = 22;
    localparam int RS1_LO     = 18;
    localparam int RS2_HI     = 17;
    localparam int RS2_LO     = 13;
    localparam int IMM_EN_BIT = 12;
    localparam int IMM_HI     = 11;
    localparam int IMM_LO     = 0;

    // ALU operation select, carried unchanged from instr to the ALU
    typedef enum logic [3:0] {
        SEL_ADD   = 4'h0,
        SEL_SUB   = 4'h1,
        SEL_AND   = 4'h2,
        SEL_OR    = 4'h3,
        SEL_XOR   = 4'h4,
        SEL_SLL   = 4'h5,
        SEL_SRL   = 4'h6,
        SEL_SRA   = 4'h7,
        SEL_SLT   = 4'h8,
        SEL_SLTU  = 4'h9,
        SEL_PASSA = 4'hA,
        SEL_PASSB = 4'hB,
        SEL_MUL   = 4'hC,
        SEL_MULH  = 4'hD,
        SEL_RSV0  = 4'hE,
        SEL_RSV1  = 4'hF
    } alu_sel_e;

    // Sign-extend the 12-bit immediate to the machine width
    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/mspc_v_regfile.sv
// 32 x 64 register file: two asynchronous read ports, one synchronous write
// port. x0 is hardwired to zero; writes to it are dropped and reads return 0.
// Contents are deliberately not reset.
module mspc_v_regfile
    import mspc_v_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [XLEN-1:0]   rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_b
);

    logic [XLEN-1:0] mem [NREG];

    // Synchronous write; x0 is never stored
    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/mspc_v_decode_fetch.sv
// Decode/operand-fetch stage: reads operands from the register file (with a
// same-cycle writeback bypass), tracks outstanding destinations in a busy
// scoreboard, stalls on RAW/WAW hazards and presents a registered operation
// to the ALU.
//
// Handshakes: both instr and alu channels are valid/ready. A transfer happens
// on a rising edge where valid and ready are both high; the producer keeps
// valid and payload stable until that transfer, and ready may depend
// combinationally on valid's payload but valid never depends on ready.
module mspc_v_decode_fetch
    import mspc_v_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [XLEN-1:0]    inpa,
    output logic [XLEN-1:0]    inpb,
    output logic [3:0]         sel,
    output logic [REG_AW-1:0]  alu_rd,
    output logic [15:0]        stall_cnt
);

    // Decoded instruction fields
    logic [3:0]        f_sel;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs1;
    logic [REG_AW-1:0] f_rs2;
    logic              f_imm_en;
    logic [11:0]       f_imm12;

    assign f_sel    = instr[SEL_HI:SEL_LO];
    assign f_rd     = instr[RD_HI:RD_LO];
    assign f_rs1    = instr[RS1_HI:RS1_LO];
    assign f_rs2    = instr[RS2_HI:RS2_LO];
    assign f_imm_en = instr[IMM_EN_BIT];
    assign f_imm12  = instr[IMM_HI:IMM_LO];

    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic            busy_rs1;
    logic            busy_rs2;
    logic            busy_rd;
    logic            hazard;
    logic            accept;
    alu_sel_e        sel_q;

    // A reset cycle must not commit writeback data
    mspc_v_regfile u_regfile (
        .clk     (clk),
        .we      (wb_valid & ~rst),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (f_rs1),
        .rdata_a (rf_a),
        .raddr_b (f_rs2),
        .rdata_b (rf_b)
    );

    // Hazard detection: a pending register stops being busy in the cycle its
    // writeback arrives, since the bypass below supplies the value
    always_comb begin
        busy_rs1 = sb[f_rs1] && !(wb_valid && (wb_rd == f_rs1));
        busy_rs2 = sb[f_rs2] && !(wb_valid && (wb_rd == f_rs2));
        busy_rd  = sb[f_rd]  && !(wb_valid && (wb_rd == f_rd));
        hazard   = busy_rs1 | (busy_rs2 & ~f_imm_en) | busy_rd;
    end

    assign instr_ready = ~rst & (~alu_valid | alu_ready) & ~hazard;
    assign accept      = instr_valid & instr_ready;

    // Operand selection with write-through bypass from the writeback port
    always_comb begin
        op_a = rf_a;
        op_b = rf_b;
        if (wb_valid && (wb_rd == f_rs1) && (f_rs1 != '0)) begin
            op_a = wb_data;
        end
        if (wb_valid && (wb_rd == f_rs2) && (f_rs2 != '0)) begin
            op_b = wb_data;
        end
        if (f_imm_en) begin
            op_b = sext_imm12(f_imm12);
        end
    end

    // Scoreboard next state: clear on writeback, then set on issue so that
    // an issue to the same register in the same cycle leaves it busy
    always_comb begin
        sb_next = sb;
        if (wb_valid) begin
            sb_next[wb_rd] = 1'b0;
        end
        if (accept && (f_rd != '0)) begin
            sb_next[f_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // ALU output register: load on accept, hold under backpressure
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid <= 1'b0;
            inpa      <= '0;
            inpb      <= '0;
            sel_q     <= SEL_ADD;
            alu_rd    <= '0;
        end else if (accept) begin
            alu_valid <= 1'b1;
            inpa      <= op_a;
            inpb      <= op_b;
            sel_q     <= alu_sel_e'(f_sel);
            alu_rd    <= f_rd;
        end else if (alu_ready) begin
            alu_valid <= 1'b0;
        end
    end

    assign sel = sel_q;

    // Saturating count of cycles an offered instruction is held by a hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (instr_valid && hazard && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
